// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and state types for the VGA text console write path.
package vga_console_pkg;

    localparam int unsigned COLS_DEFAULT       = 80;
    localparam int unsigned ROWS_DEFAULT       = 60;
    localparam logic [7:0]  BLANK_CHAR_DEFAULT = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [10:0] BLANK_WORD = {3'b000, BLANK_CHAR_DEFAULT};

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } console_state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_NL,
        CUR_CR,
        CUR_BS,
        CUR_HOME
    } cursor_cmd_e;

    function automatic logic [10:0] blank_word(input logic [7:0] blank_char);
        return {3'b000, blank_char};
    endfunction

endpackage

// File: rtl/vga_cursor.sv
// Text cursor position register: advance with wrap, newline, carriage return,
// backspace within the line, and home.
module vga_cursor
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  cursor_cmd_e i_cmd,
    output logic [6:0]  o_col,
    output logic [5:0]  o_row
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    logic [6:0] r_col;
    logic [5:0] r_row;
    logic [5:0] w_row_inc;

    assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            case (i_cmd)
                CUR_ADV: begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= w_row_inc;
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                end
                CUR_NL: begin
                    r_col <= '0;
                    r_row <= w_row_inc;
                end
                CUR_CR: r_col <= '0;
                // Backspace never retreats onto the previous row.
                CUR_BS: if (r_col != '0) r_col <= r_col - 7'd1;
                CUR_HOME: begin
                    r_col <= '0;
                    r_row <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;

endmodule

// File: rtl/vga_text_console.sv
// Character-stream front end for the text VRAM: interprets control codes, tracks
// the cursor and streams blank words for line and screen clears.
module vga_text_console
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS       = COLS_DEFAULT,
    parameter int unsigned ROWS       = ROWS_DEFAULT,
    parameter logic [7:0]  BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [7:0]  ch_data,
    input  logic [2:0]  ch_color,
    output logic        vram_we,
    output logic [12:0] vram_waddr,
    output logic [10:0] vram_wdata,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
    localparam logic [10:0] W_BLANK  = blank_word(BLANK_CHAR);

    console_state_e r_state, w_state_nxt;
    logic [6:0]     r_clr_col, w_clr_col_nxt;
    logic [5:0]     r_clr_row, w_clr_row_nxt;
    logic           r_clr_done, w_clr_done_nxt;
    logic           r_we, w_we_nxt;
    logic [12:0]    r_waddr, w_waddr_nxt;
    logic [10:0]    r_wdata, w_wdata_nxt;
    logic           r_busy;
    cursor_cmd_e    w_cmd;
    logic [6:0]     w_cur_col;
    logic [5:0]     w_cur_row;

    vga_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk   (clk),
        .reset (reset),
        .i_cmd (w_cmd),
        .o_col (w_cur_col),
        .o_row (w_cur_row)
    );

    assign ch_ready = (r_state == IDLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_col_nxt  = r_clr_col;
        w_clr_row_nxt  = r_clr_row;
        w_clr_done_nxt = r_clr_done;
        w_we_nxt       = 1'b0;
        w_waddr_nxt    = r_waddr;
        w_wdata_nxt    = r_wdata;
        w_cmd          = CUR_NONE;
        case (r_state)
            IDLE: begin
                if (ch_valid) begin
                    case (ch_data)
                        CH_LF: begin
                            w_cmd          = CUR_NL;
                            w_state_nxt    = CLR_LINE;
                            w_clr_col_nxt  = '0;
                            w_clr_done_nxt = 1'b0;
                        end
                        CH_CR: w_cmd = CUR_CR;
                        CH_BS: begin
                            if (w_cur_col != '0) begin
                                w_cmd       = CUR_BS;
                                w_we_nxt    = 1'b1;
                                w_waddr_nxt = {w_cur_row, w_cur_col - 7'd1};
                                w_wdata_nxt = W_BLANK;
                            end
                        end
                        CH_FF: begin
                            w_cmd          = CUR_HOME;
                            w_state_nxt    = CLR_SCREEN;
                            w_clr_col_nxt  = '0;
                            w_clr_row_nxt  = '0;
                            w_clr_done_nxt = 1'b0;
                        end
                        default: begin
                            w_cmd       = CUR_ADV;
                            w_we_nxt    = 1'b1;
                            w_waddr_nxt = {w_cur_row, w_cur_col};
                            w_wdata_nxt = {ch_color, ch_data};
                            if (w_cur_col == LAST_COL) begin
                                w_state_nxt    = CLR_LINE;
                                w_clr_col_nxt  = '0;
                                w_clr_done_nxt = 1'b0;
                            end
                        end
                    endcase
                end
            end
            // Cursor row already points at the new line when this state is entered.
            CLR_LINE: begin
                if (r_clr_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = {w_cur_row, r_clr_col};
                    w_wdata_nxt = W_BLANK;
                    if (r_clr_col == LAST_COL) w_clr_done_nxt = 1'b1;
                    else                       w_clr_col_nxt  = r_clr_col + 7'd1;
                end
            end
            CLR_SCREEN: begin
                if (r_clr_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = {r_clr_row, r_clr_col};
                    w_wdata_nxt = W_BLANK;
                    if (r_clr_col == LAST_COL) begin
                        w_clr_col_nxt = '0;
                        if (r_clr_row == LAST_ROW) w_clr_done_nxt = 1'b1;
                        else                       w_clr_row_nxt  = r_clr_row + 6'd1;
                    end else begin
                        w_clr_col_nxt = r_clr_col + 7'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= CLR_SCREEN;
            r_clr_col  <= '0;
            r_clr_row  <= '0;
            r_clr_done <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_col  <= w_clr_col_nxt;
            r_clr_row  <= w_clr_row_nxt;
            r_clr_done <= w_clr_done_nxt;
            r_we       <= w_we_nxt;
            r_waddr    <= w_waddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign vram_we    = r_we;
    assign vram_waddr = r_waddr;
    assign vram_wdata = r_wdata;
    assign cursor_col = w_cur_col;
    assign cursor_row = w_cur_row;
    assign busy       = r_busy;

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboard bench for vga_text_console: a reference cursor model queues every
// expected VRAM word at stimulus time; a negedge monitor pops and compares.
module tb_vga_text_console;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic [7:0]  ch_data = '0;
    logic [2:0]  ch_color = '0;
    logic        vram_we;
    logic [12:0] vram_waddr;
    logic [10:0] vram_wdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    always #5 clk = ~clk;

    vga_text_console #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_data    (ch_data),
        .ch_color   (ch_color),
        .vram_we    (vram_we),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q[$];
    int          wr_cyc_q[$];
    int          n_wr = 0;
    int          cyc = 0;
    int          m_col = 0;
    int          m_row = 0;
    logic [23:0] e_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (vram_we === 1'b1) begin
            n_wr++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {8'h0, vram_waddr, vram_wdata}, 32'hFFFF_FFFF);
            end else begin
                e_w = exp_q.pop_front();
                check("wr", {8'h0, vram_waddr, vram_wdata}, {8'h0, e_w});
            end
        end
    end

    task automatic push_wr(input int row, input int col, input logic [10:0] data);
        logic [5:0] r;
        logic [6:0] c;
        r = row[5:0];
        c = col[6:0];
        exp_q.push_back({r, c, data});
    endtask

    task automatic push_clear_line(input int row);
        for (int c = 0; c < COLS; c++) push_wr(row, c, 11'h020);
    endtask

    task automatic push_clear_screen();
        for (int r = 0; r < ROWS; r++) push_clear_line(r);
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    endtask

    task automatic model_apply(input logic [7:0] ch, input logic [2:0] color);
        case (ch)
            8'h0A: begin model_newline(); push_clear_line(m_row); end
            8'h0D: m_col = 0;
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    push_wr(m_row, m_col, 11'h020);
                end
            end
            8'h0C: begin m_col = 0; m_row = 0; push_clear_screen(); end
            default: begin
                push_wr(m_row, m_col, {color, ch});
                if (m_col == COLS - 1) begin
                    model_newline();
                    push_clear_line(m_row);
                end else begin
                    m_col++;
                end
            end
        endcase
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (ch_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'b0, ch_ready}, 32'd1);
        #1;
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic send(input logic [7:0] ch, input logic [2:0] color);
        wait_ready();
        ch_valid = 1'b1;
        ch_data  = ch;
        ch_color = color;
        model_apply(ch, color);
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        wait_ready();
        check({tag, "_col"}, {25'b0, cursor_col}, col);
        check({tag, "_row"}, {26'b0, cursor_row}, row);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",    {31'b0, vram_we}, 32'd0);
        check("rst_waddr", {19'b0, vram_waddr}, 32'd0);
        check("rst_wdata", {21'b0, vram_wdata}, 32'd0);
        check("rst_ready", {31'b0, ch_ready}, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd1);
        push_clear_screen();
        #2 reset = 1'b0;
        @(negedge clk);
        check("init_ready_low", {31'b0, ch_ready}, 32'd0);
        check_cursor("init", 0, 0);
        check("init_busy", {31'b0, busy}, 32'd0);

        send(8'h41, 3'b100);
        check_cursor("after_A", 1, 0);

        // Back-to-back characters with valid held high.
        wait_ready();
        ch_valid = 1'b1;
        ch_color = 3'b001;
        ch_data  = 8'h42;
        model_apply(8'h42, 3'b001);
        @(posedge clk);
        #1;
        check("burst_ready", {31'b0, ch_ready}, 32'd1);
        ch_data = 8'h43;
        model_apply(8'h43, 3'b001);
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        check_cursor("after_BC", 3, 0);
        n = wr_cyc_q.size();
        check("burst_consec", wr_cyc_q[n-1] - wr_cyc_q[n-2], 32'd1);

        send(8'h0D, 3'b000);
        for (int i = 0; i < COLS - 1; i++) send(8'h61 + 8'(i % 26), 3'b010);
        check_cursor("at_col79", 79, 0);
        send(8'h5A, 3'b111);
        @(negedge clk);
        check("wrap_ready_low", {31'b0, ch_ready}, 32'd0);
        check("wrap_busy", {31'b0, busy}, 32'd1);
        check_cursor("after_Z", 0, 1);

        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 3'b000);
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 3'b011);
        check_cursor("at_row59", 10, 59);
        base = n_wr;
        send(8'h0A, 3'b000);
        check_cursor("lf_wrap", 0, 0);
        check("lf_wrap_count", n_wr - base, COLS);

        for (int i = 0; i < 3; i++) send(8'h0A, 3'b000);
        for (int i = 0; i < 5; i++) send(8'h78, 3'b101);
        check_cursor("pre_bs", 5, 3);
        send(8'h08, 3'b111);
        check_cursor("bs", 4, 3);
        send(8'h0D, 3'b000);
        base = n_wr;
        send(8'h08, 3'b000);
        check_cursor("bs_col0", 0, 3);
        check("bs_col0_nowrite", n_wr - base, 32'd0);

        for (int i = 0; i < 4; i++) send(8'h0A, 3'b000);
        for (int i = 0; i < 40; i++) send(8'h79, 3'b110);
        check_cursor("pre_cr", 40, 7);
        base = n_wr;
        send(8'h0D, 3'b000);
        check_cursor("cr", 0, 7);
        check("cr_nowrite", n_wr - base, 32'd0);

        // Abort a full-screen clear with reset part way through.
        send(8'h0C, 3'b000);
        base = n_wr;
        n = 0;
        while (n_wr < base + 100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ff_progress", {31'b0, (n_wr >= base + 100)}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_we",    {31'b0, vram_we}, 32'd0);
        check("abort_waddr", {19'b0, vram_waddr}, 32'd0);
        check("abort_wdata", {21'b0, vram_wdata}, 32'd0);
        check("abort_ready", {31'b0, ch_ready}, 32'd0);
        check("abort_busy",  {31'b0, busy}, 32'd1);
        check("abort_col",   {25'b0, cursor_col}, 32'd0);
        check("abort_row",   {26'b0, cursor_row}, 32'd0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (2) @(negedge clk);
        check("abort_we_hold", {31'b0, vram_we}, 32'd0);
        base = n_wr;
        push_clear_screen();
        #2 reset = 1'b0;
        check_cursor("reclear", 0, 0);
        check("reclear_count", n_wr - base, ROWS * COLS);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
